// File: rtl/adpcm_pkg.sv
// Shared definitions for the ADPCM block packer: write FSM states,
// header layout constants and the packed FIFO entry format.
package adpcm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    HDR2,
    HDR3,
    DATA_HI,
    DATA_LO
  } wr_state_t;

  localparam int unsigned HDR_LEN       = 4;
  localparam logic [7:0]  HDR3_RESERVED = 8'h00;

  // 10-bit FIFO word: block framing flags plus the stream byte.
  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/adpcm_block_packer_if.sv
// Byte stream leaving the packer: valid/ready handshake with block framing flags.
interface adpcm_block_packer_if;
  logic [7:0] outByte;
  logic       outValid;
  logic       outReady;
  logic       outFirst;
  logic       outLast;

  modport master (
    output outByte,
    output outValid,
    output outFirst,
    output outLast,
    input  outReady
  );

  modport slave (
    input  outByte,
    input  outValid,
    input  outFirst,
    input  outLast,
    output outReady
  );
endinterface

// File: rtl/adpcm_byte_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is visible combinationally
// and reads as zero while empty.
module adpcm_byte_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  // A read in the same cycle frees the slot, so a write into a full FIFO is still taken.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted writes and reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array write.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/adpcm_block_packer.sv
// Packs ADPCM nibbles into blocks: a 4-byte encoder-state header followed by
// nibble-pair data bytes, buffered through a byte FIFO with framing flags.
module adpcm_block_packer
  import adpcm_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_BLOCK = 16,
  parameter int unsigned FIFO_DEPTH        = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [3:0]                   inPCM,
  input  logic                         inValid,
  input  logic [15:0]                  inPredictSamp,
  input  logic [6:0]                   inStepIndex,
  adpcm_block_packer_if.master         stream,
  output logic                         overflow,
  input  logic                         clearOverflow
);

  localparam logic [6:0] LAST_BYTE = 7'(SAMPLES_PER_BLOCK / 2 - 1);

  wr_state_t   state;
  logic [3:0]  low_nib;
  logic [6:0]  byte_cnt;
  logic [15:0] snap_pred;
  logic [6:0]  snap_idx;

  logic        in_hdr;
  logic        wr_en;
  fifo_entry_t wr_entry;
  fifo_entry_t head;
  logic        rd_en;
  logic        full;
  logic        empty;
  logic        hdr_drop;
  logic        fifo_drop;

  assign in_hdr    = (state == HDR0) || (state == HDR1) || (state == HDR2) || (state == HDR3);
  assign hdr_drop  = inValid && in_hdr;
  assign rd_en     = !empty && stream.outReady;
  assign fifo_drop = wr_en && full && !rd_en;

  // Select the byte written to the FIFO this cycle from the FSM state.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = '0;
    case (state)
      HDR0: begin
        wr_en    = 1'b1;
        wr_entry = '{first: 1'b1, last: 1'b0, data: snap_pred[7:0]};
      end
      HDR1: begin
        wr_en    = 1'b1;
        wr_entry = '{first: 1'b0, last: 1'b0, data: snap_pred[15:8]};
      end
      HDR2: begin
        wr_en    = 1'b1;
        wr_entry = '{first: 1'b0, last: 1'b0, data: {1'b0, snap_idx}};
      end
      HDR3: begin
        wr_en    = 1'b1;
        wr_entry = '{first: 1'b0, last: 1'b0, data: HDR3_RESERVED};
      end
      DATA_HI: begin
        wr_en    = inValid;
        wr_entry = '{first: 1'b0, last: (byte_cnt == LAST_BYTE), data: {inPCM, low_nib}};
      end
      default: begin
        wr_en    = 1'b0;
        wr_entry = '0;
      end
    endcase
  end

  // Block write sequencer: header bytes, then pair nibbles into data bytes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      low_nib  <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            low_nib  <= inPCM;
            byte_cnt <= '0;
            state    <= HDR0;
          end
        end
        HDR0: state <= HDR1;
        HDR1: state <= HDR2;
        HDR2: state <= HDR3;
        HDR3: state <= DATA_HI;
        DATA_HI: begin
          if (inValid) begin
            byte_cnt <= byte_cnt + 7'd1;
            state    <= (byte_cnt == LAST_BYTE) ? IDLE : DATA_LO;
          end
        end
        DATA_LO: begin
          if (inValid) begin
            low_nib <= inPCM;
            state   <= DATA_HI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Encoder-state snapshot. Held through the header states as well as the
  // start cycle, since inValid is low there and would otherwise pull in the
  // post-first-nibble state before H1/H2 are written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_pred <= '0;
      snap_idx  <= '0;
    end else if (!inValid && !in_hdr) begin
      snap_pred <= inPredictSamp;
      snap_idx  <= inStepIndex;
    end
  end

  // Sticky overflow; a new drop event takes priority over the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (hdr_drop || fifo_drop) begin
      overflow <= 1'b1;
    end else if (clearOverflow) begin
      overflow <= 1'b0;
    end
  end

  adpcm_byte_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign stream.outValid = !empty;
  assign stream.outByte  = head.data;
  assign stream.outFirst = head.first;
  assign stream.outLast  = head.last;

endmodule

// File: tb/tb_adpcm_block_packer.sv
// Scoreboard bench for adpcm_block_packer: a cycle-level reference model
// predicts every byte accepted into the output FIFO; a negedge monitor
// pops and compares each transferred byte.
module tb_adpcm_block_packer;

  localparam int unsigned SPB   = 4;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  inPCM = '0;
  logic        inValid = 1'b0;
  logic [15:0] inPredictSamp = '0;
  logic [6:0]  inStepIndex = '0;
  logic        overflow;
  logic        clearOverflow = 1'b0;

  adpcm_block_packer_if stream_if ();

  adpcm_block_packer #(
    .SAMPLES_PER_BLOCK (SPB),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .inPCM         (inPCM),
    .inValid       (inValid),
    .inPredictSamp (inPredictSamp),
    .inStepIndex   (inStepIndex),
    .stream        (stream_if),
    .overflow      (overflow),
    .clearOverflow (clearOverflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  exp_t       sb[$];
  exp_t       seen[$];
  logic [7:0] want_q[$];

  // Reference model state
  int          cyc = 0;
  int          c0 = 0;
  bit          in_block = 0;
  logic [3:0]  nibs[$];
  logic [15:0] last_pred = '0;
  logic [6:0]  last_idx = '0;
  logic [15:0] hdr_pred = '0;
  logic [6:0]  hdr_idx = '0;
  int          m_count = 0;
  bit          m_ovf = 0;
  bit          exp_valid = 0;
  bit          exp_ovf = 0;

  logic [15:0] cur_pred = '0;
  logic [6:0]  cur_idx = '0;
  logic        cur_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, want);
    end
  endtask

  // Predicts the effect of the coming clock edge given the inputs applied to it.
  task automatic model_edge(input logic v, input logic [3:0] n, input logic [15:0] p,
                            input logic [6:0] ix, input logic rdy, input logic clr);
    int   e;
    int   k;
    bit   wr;
    bit   set_ovf;
    bit   hdr;
    bit   rd;
    exp_t ent;
    e = cyc;
    cyc++;
    wr = 0;
    set_ovf = 0;
    ent = '0;
    hdr = in_block && (e > c0) && (e <= c0 + 4);
    if (hdr) begin
      wr = 1;
      k = e - c0;
      case (k)
        1:       ent = '{first: 1'b1, last: 1'b0, data: hdr_pred[7:0]};
        2:       ent = '{first: 1'b0, last: 1'b0, data: hdr_pred[15:8]};
        3:       ent = '{first: 1'b0, last: 1'b0, data: {1'b0, hdr_idx}};
        default: ent = '{first: 1'b0, last: 1'b0, data: 8'h00};
      endcase
      if (v) set_ovf = 1;
    end else if (v) begin
      if (!in_block) begin
        in_block = 1;
        c0 = e;
        nibs.delete();
        nibs.push_back(n);
        hdr_pred = last_pred;
        hdr_idx = last_idx;
      end else begin
        nibs.push_back(n);
        if (nibs.size() % 2 == 0) begin
          wr = 1;
          ent.first = 1'b0;
          ent.last = (nibs.size() == SPB);
          ent.data = {n, nibs[nibs.size() - 2]};
          if (ent.last) in_block = 0;
        end
      end
    end
    if (!v && !hdr) begin
      last_pred = p;
      last_idx = ix;
    end
    rd = rdy && (m_count > 0);
    if (wr) begin
      if (m_count < DEPTH || rd) begin
        sb.push_back(ent);
        m_count++;
      end else begin
        set_ovf = 1;
      end
    end
    if (rd) m_count--;
    if (set_ovf) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  // Called just after a rising edge; applies inputs for the next edge.
  task automatic drive(input logic v, input logic [3:0] n, input logic clr);
    inValid = v;
    inPCM = n;
    inPredictSamp = cur_pred;
    inStepIndex = cur_idx;
    stream_if.outReady = cur_ready;
    clearOverflow = clr;
    model_edge(v, n, cur_pred, cur_idx, cur_ready, clr);
    @(posedge clock);
    #1;
    exp_valid = (m_count > 0);
    exp_ovf = m_ovf;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic nibble(input logic [3:0] n, input int gap);
    drive(1'b1, n, 1'b0);
    idle(gap);
  endtask

  task automatic drain();
    cur_ready = 1'b1;
    for (int k = 0; k < 200 && sb.size() > 0; k++) drive(1'b0, 4'h0, 1'b0);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending required 0", sb.size());
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    inValid = 1'b0;
    clearOverflow = 1'b0;
    sb.delete();
    nibs.delete();
    m_count = 0;
    m_ovf = 0;
    in_block = 0;
    last_pred = '0;
    last_idx = '0;
    exp_valid = 0;
    exp_ovf = 0;
    @(negedge clock);
    check("rst_valid", 32'(stream_if.outValid), 32'(0));
    check("rst_byte", 32'(stream_if.outByte), 32'(0));
    check("rst_first", 32'(stream_if.outFirst), 32'(0));
    check("rst_last", 32'(stream_if.outLast), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic compare_seen(input string name);
    check({name, "_len"}, 32'(seen.size()), 32'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < seen.size(); i++)
      check($sformatf("%s_b%0d", name, i), 32'(seen[i].data), 32'(want_q[i]));
  endtask

  // Monitor: compares status every cycle and each transferred byte against the scoreboard.
  always @(negedge clock) begin
    exp_t got;
    exp_t want;
    if (!reset) begin
      check("out_valid", 32'(stream_if.outValid), 32'(exp_valid));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      if (stream_if.outValid && stream_if.outReady) begin
        got = '{first: stream_if.outFirst, last: stream_if.outLast, data: stream_if.outByte};
        seen.push_back(got);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte got %0h required none", got);
        end else begin
          want = sb.pop_front();
          check("stream_entry", 32'(got), 32'(want));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    stream_if.outReady = 1'b1;
    @(posedge clock);
    #1;
    apply_reset();

    // Basic block
    cur_pred = 16'h1234;
    cur_idx = 7'd10;
    cur_ready = 1'b1;
    idle(2);
    seen.delete();
    for (int n = 1; n <= 4; n++) nibble(4'(n), 7);
    drain();
    want_q = '{8'h34, 8'h12, 8'h0A, 8'h00, 8'h21, 8'h43};
    compare_seen("basic");
    if (seen.size() == 6) begin
      check("basic_first", 32'(seen[0].first), 32'(1));
      check("basic_last", 32'(seen[5].last), 32'(1));
    end

    // Negative predictor header
    cur_pred = 16'hFF80;
    cur_idx = 7'd88;
    idle(2);
    seen.delete();
    nibble(4'h9, 6);
    nibble(4'hA, 2);
    nibble(4'hB, 2);
    nibble(4'hC, 2);
    drain();
    want_q = '{8'h80, 8'hFF, 8'h58, 8'h00, 8'hA9, 8'hCB};
    compare_seen("negpred");

    // Stalled consumer: overflow, clear, then write into a full FIFO while reading
    cur_pred = 16'h1234;
    cur_idx = 7'd10;
    idle(2);
    seen.delete();
    cur_ready = 1'b0;
    for (int n = 1; n <= 4; n++) nibble(4'(n), 7);
    check("stall_overflow", 32'(overflow), 32'(1));
    check("stall_valid", 32'(stream_if.outValid), 32'(1));
    drive(1'b0, 4'h0, 1'b1);
    check("stall_cleared", 32'(overflow), 32'(0));
    drive(1'b1, 4'h5, 1'b0);
    cur_ready = 1'b1;
    idle(7);
    nibble(4'h6, 7);
    nibble(4'h7, 7);
    nibble(4'h8, 7);
    drain();
    check("wrap_no_overflow", 32'(overflow), 32'(0));
    want_q = '{8'h34, 8'h12, 8'h0A, 8'h00, 8'h34, 8'h12, 8'h0A, 8'h00, 8'h65, 8'h87};
    compare_seen("wrap");

    // Nibble during header
    idle(2);
    seen.delete();
    nibble(4'h5, 2);
    nibble(4'h6, 6);
    nibble(4'h7, 2);
    nibble(4'h8, 2);
    nibble(4'h9, 2);
    drain();
    check("hdr_drop_overflow", 32'(overflow), 32'(1));
    want_q = '{8'h34, 8'h12, 8'h0A, 8'h00, 8'h75, 8'h98};
    compare_seen("hdr_drop");
    drive(1'b0, 4'h0, 1'b1);

    // Reset in the middle of a block
    idle(2);
    nibble(4'h1, 6);
    nibble(4'h2, 2);
    apply_reset();
    seen.delete();
    idle(2);
    nibble(4'h3, 6);
    nibble(4'h4, 2);
    nibble(4'h5, 2);
    nibble(4'h6, 2);
    drain();
    want_q = '{8'h34, 8'h12, 8'h0A, 8'h00, 8'h43, 8'h65};
    compare_seen("post_reset");
    if (seen.size() > 0) check("post_reset_first", 32'(seen[0].first), 32'(1));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cur_pred = 16'($urandom);
      cur_idx = 7'($urandom);
      cur_ready = ($urandom_range(0, 3) != 0);
      if (i == 1500) apply_reset();
      drive($urandom_range(0, 2) == 0, 4'($urandom), $urandom_range(0, 15) == 0);
    end
    idle(12);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adpcm_block_packer.md
ADPCM_BLOCK_PACKER -- requirements
Module: adpcm_block_packer

Interface
REQ-001 Parameter SAMPLES_PER_BLOCK, default 16, nibbles per block; shall be even and in the range 2..254.
REQ-002 Parameter FIFO_DEPTH, default 8, output byte FIFO entries; shall be a power of 2 and at least 4.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 inPCM  input  4  ADPCM nibble from the encoder.
REQ-006 inValid  input  1  one-cycle nibble strobe.
REQ-007 inPredictSamp  input  16  encoder predictor; already updated in the inValid cycle.
REQ-008 inStepIndex  input  7  encoder step index; already updated in the inValid cycle.
REQ-009 outByte  output  8  packed stream byte (FIFO head).
REQ-010 outValid  output  1  FIFO non-empty.
REQ-011 outReady  input  1  consumer accepts; a byte transfers when outValid and outReady are both high.
REQ-012 outFirst  output  1  outByte is header byte 0 of a block.
REQ-013 outLast  output  1  outByte is the final data byte of a block.
REQ-014 overflow  output  1  sticky error flag.
REQ-015 clearOverflow  input  1  synchronous clear of overflow.

Function
REQ-016 Each block shall carry 4 header bytes followed by SAMPLES_PER_BLOCK/2 data bytes.
REQ-017 Header byte order: H0=pred[7:0], H1=pred[15:8], H2={1'b0,stepIndex}, H3=8'h00.
REQ-018 Header fields shall be the encoder state before the block's first nibble: snapshot registers load inPredictSamp/inStepIndex on every cycle in which inValid is low.
REQ-019 Data byte = {second nibble, first nibble}; the first nibble goes in bits [3:0].
REQ-020 Write FSM states: IDLE, HDR0, HDR1, HDR2, HDR3, DATA_HI, DATA_LO.
REQ-021 IDLE with inValid: latch inPCM as the low nibble and freeze the snapshot; go to HDR0.
REQ-022 HDR0..HDR3: each state writes one header byte to the FIFO in its cycle; HDR3 goes to DATA_HI.
REQ-023 DATA_HI with inValid: write a data byte and increment the byte count; at the last byte go to IDLE, otherwise go to DATA_LO.
REQ-024 DATA_LO with inValid: latch the low nibble; go to DATA_HI.
REQ-025 An inValid arriving in any HDRx state shall be dropped and shall set overflow; the FSM shall not stall.
REQ-026 FIFO entries shall be 10 bits, {first,last,byte}; outFirst is set on H0 and outLast on the final data byte.
REQ-027 A write while the FIFO is full shall be dropped and shall set overflow; FSM progress shall continue unchanged.
REQ-028 A simultaneous read and write when full shall be accepted; no drop and no overflow.
REQ-029 Outputs shall come from the FIFO head with zero added latency; the first write makes outValid high on the next cycle.
REQ-030 FIFO pointers shall be log2(FIFO_DEPTH)+1 bits with wrap-around; full when the MSBs differ and the low bits are equal.
REQ-031 clearOverflow shall clear the flag; a new overflow event in the same cycle shall win.
REQ-032 The byte counter shall be 7 bits and reset to 0 on leaving IDLE.

Reset
REQ-033 Reset shall set: FSM to IDLE, FIFO empty, outValid=0, outFirst=0, outLast=0, outByte=0, overflow=0, snapshot=0, counters=0.
REQ-034 Reset mid-block shall discard the partial block and FIFO contents; the first nibble after reset shall start a new header.

Structure
REQ-035 The shared package adpcm_pkg shall hold the FSM state encoding, the header length constant (4), and the H3 reserved value (8'h00).
REQ-036 The FIFO shall be a sub-module adpcm_byte_fifo, parameterised by width 10 and FIFO_DEPTH, exposing full and empty.

Verification
REQ-037 SAMPLES_PER_BLOCK=4, snapshot pred=16'h1234, idx=7'd10, nibbles 1,2,3,4 at 8-cycle spacing, outReady=1 -> bytes 34,12,0A,00,21,43; outFirst on 34; outLast on 43.
REQ-038 Negative predictor 16'hFF80, idx=88 -> header bytes 80,FF,58,00.
REQ-039 outReady=0, FIFO_DEPTH=4, one block of 6 bytes -> first 4 bytes stored, 2 dropped, overflow=1; after release 34,12,0A,00 emerge; clearOverflow -> overflow=0.
REQ-040 A second nibble 2 cycles after the first (during HDR2) -> overflow=1, nibble absent from output, header intact.
REQ-041 Reset asserted in DATA_LO -> outValid=0 next cycle; the next nibble yields a fresh H0 with outFirst=1.
REQ-042 Full FIFO with outReady=1 and a simultaneous write -> no overflow; byte order preserved across pointer wrap.
